// File: rtl/counter_write_control.sv
// counter_write_control: owns the L2 / I-cache / D-cache hit and miss
// counters. Each counter increments on its per-cycle event pulse. A CPU store
// into the counter window clears or presets a counter through a three-state
// IDLE -> COMMIT -> DONE handshake.
// Counter order: l2_miss, l2_hit, icache_miss, icache_hit, dcache_miss,
// dcache_hit.
// Optional build macro PERF_COUNTER_SATURATE_EN makes counters saturate at
// 16'hFFFF. Without it, counters wrap modulo 2^16.

// One counter lane: byte-masked store write, or an increment.
module counter_write_control_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic [15:0] cnt
);
  // A store to this lane wins over the increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (wr_en) begin
      cnt <= {wr_be[1] ? wr_data[15:8] : cnt[15:8],
              wr_be[0] ? wr_data[7:0]  : cnt[7:0]};
    end else if (inc) begin
`ifdef PERF_COUNTER_SATURATE_EN
      if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
`else
      cnt <= cnt + 16'd1;
`endif
    end
  end
endmodule

module counter_write_control #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0,
  parameter int          NUM_CNT   = 6,
  parameter int          WINDOW    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           mem_address,
  input  logic                  mem_write,
  input  logic [15:0]           mem_wdata,
  input  logic [1:0]            mem_byte_enable,
  input  logic [NUM_CNT-1:0]    inc,
  output logic                  counter_write_sel,
  output logic                  mem_resp,
  output logic [16*NUM_CNT-1:0] count
);
  typedef enum logic [1:0] {IDLE, COMMIT, DONE} state_t;

  // The window end is computed in 17 bits because the default window ends
  // exactly at the top of the 16-bit address space.
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(WINDOW);

  state_t                   state_q, state_d;
  logic [15:0]              offset_q;
  logic [15:0]              wdata_q;
  logic [1:0]               be_q;
  logic [NUM_CNT-1:0][15:0] cnt_arr;

  // Window decode: combinational on the address and mem_write only.
  always_comb begin
    counter_write_sel = mem_write &&
                        ({1'b0, mem_address} >= WIN_LO) &&
                        ({1'b0, mem_address} <  WIN_HI);
  end

  // State register plus the store capture taken when a request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      offset_q <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && counter_write_sel) begin
        offset_q <= mem_address - BASE_ADDR;
        wdata_q  <= mem_wdata;
        be_q     <= mem_byte_enable;
      end
    end
  end

  // Next state and the ack. DONE burns one cycle so a mem_write still held
  // high after the ack is not taken as a second request.
  always_comb begin
    state_d  = state_q;
    mem_resp = 1'b0;
    case (state_q)
      IDLE:    if (counter_write_sel) state_d = COMMIT;
      COMMIT: begin
        mem_resp = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One lane per counter. An offset at or above NUM_CNT matches no lane, so
  // the store is acked and its data dropped. With be=00 no byte is written,
  // so that cycle's increment is kept.
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_lane
    counter_write_control_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[k]),
      .wr_en   ((state_q == COMMIT) && (offset_q == 16'(k)) && (|be_q)),
      .wr_data (wdata_q),
      .wr_be   (be_q),
      .cnt     (cnt_arr[k])
    );
  end

  assign count = cnt_arr;
endmodule

// File: tb/tb_counter_write_control.sv
// Directed bench for counter_write_control. Every expected value is worked
// out by hand.
module tb_counter_write_control;
  localparam int NUM_CNT = 6;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           mem_address;
  logic                  mem_write;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_byte_enable;
  logic [NUM_CNT-1:0]    inc;
  logic                  counter_write_sel;
  logic                  mem_resp;
  logic [16*NUM_CNT-1:0] count;

  int vectors = 0;
  int errs    = 0;

  counter_write_control #(.BASE_ADDR(16'hFFF0), .NUM_CNT(NUM_CNT), .WINDOW(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_address       (mem_address),
    .mem_write         (mem_write),
    .mem_wdata         (mem_wdata),
    .mem_byte_enable   (mem_byte_enable),
    .inc               (inc),
    .counter_write_sel (counter_write_sel),
    .mem_resp          (mem_resp),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input int k);
    return count[16*k +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full store handshake. mem_write drops once the ack has been seen.
  // hit is the expected in-window decode.
  task automatic do_store(input string tag, input logic [15:0] addr,
                          input logic [15:0] data, input logic [1:0] be,
                          input logic hit);
    mem_address     = addr;
    mem_wdata       = data;
    mem_byte_enable = be;
    mem_write       = 1'b1;
    #1;
    chk({tag, " sel"}, 32'(counter_write_sel), 32'(hit));
    tick();
    chk({tag, " resp"}, 32'(mem_resp), 32'(hit));
    mem_write = 1'b0;
    tick();
    chk({tag, " resp_drop"}, 32'(mem_resp), 32'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_address = '0; mem_write = 1'b0; mem_wdata = '0;
    mem_byte_enable = '0; inc = '0;
    tick(); tick();
    chk("reset count lo", count[31:0], 32'd0);
    chk("reset count hi", 32'(count[95:32]), 32'd0);
    chk("reset resp", 32'(mem_resp), 32'd0);
    chk("reset sel", 32'(counter_write_sel), 32'd0);
    reset = 1'b0;
    tick();

    // inc[0] for five cycles
    inc = 6'b000001;
    repeat (5) tick();
    inc = '0;
    chk("inc0 x5", 32'(cnt_of(0)), 32'd5);
    chk("others idle", 32'(count[95:16]), 32'd0);

    // full-word store
    do_store("st3", 16'hFFF3, 16'h1234, 2'b11, 1'b1);
    chk("cnt3 full", 32'(cnt_of(3)), 32'h1234);

    // byte-enable writes to counter 2
    do_store("pre2", 16'hFFF2, 16'hABCD, 2'b11, 1'b1);
    chk("cnt2 preset", 32'(cnt_of(2)), 32'hABCD);
    do_store("lo2", 16'hFFF2, 16'h0055, 2'b01, 1'b1);
    chk("cnt2 lo byte", 32'(cnt_of(2)), 32'hAB55);
    do_store("be00", 16'hFFF2, 16'h9999, 2'b00, 1'b1);
    chk("cnt2 be00", 32'(cnt_of(2)), 32'hAB55);
    do_store("hi2", 16'hFFF2, 16'h7700, 2'b10, 1'b1);
    chk("cnt2 hi byte", 32'(cnt_of(2)), 32'h7755);

    // Store beats increment on counter 4; counter 5 keeps counting.
    inc = 6'b110000;
    mem_address = 16'hFFF4; mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
    mem_write = 1'b1;
    tick();                                   // now in COMMIT
    chk("c4 resp", 32'(mem_resp), 32'd1);
    chk("c4 pre", 32'(cnt_of(4)), 32'd1);
    chk("c5 a", 32'(cnt_of(5)), 32'd1);
    mem_write = 1'b0;
    tick();
    chk("c4 written", 32'(cnt_of(4)), 32'd0);
    chk("c5 b", 32'(cnt_of(5)), 32'd2);
    tick();
    chk("c4 +1", 32'(cnt_of(4)), 32'd1);
    chk("c5 c", 32'(cnt_of(5)), 32'd3);
    tick();
    chk("c4 +2", 32'(cnt_of(4)), 32'd2);
    chk("c5 d", 32'(cnt_of(5)), 32'd4);
    inc = '0;

    // wrap or saturate
    do_store("pre1", 16'hFFF1, 16'hFFFE, 2'b11, 1'b1);
    inc = 6'b000010;
    repeat (3) tick();
    inc = '0;
`ifdef PERF_COUNTER_SATURATE_EN
    chk("cnt1 saturate", 32'(cnt_of(1)), 32'hFFFF);
`else
    chk("cnt1 wrap", 32'(cnt_of(1)), 32'h0001);
`endif

    // reset in the middle of COMMIT
    mem_address = 16'hFFF0; mem_wdata = 16'h9999; mem_byte_enable = 2'b11;
    mem_write = 1'b1;
    tick();
    chk("rst commit resp", 32'(mem_resp), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst resp drop", 32'(mem_resp), 32'd0);
    chk("rst cnt0", 32'(cnt_of(0)), 32'd0);
    chk("rst cnt3", 32'(cnt_of(3)), 32'd0);
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("no pending wr", 32'(cnt_of(0)), 32'd0);
    chk("post rst resp", 32'(mem_resp), 32'd0);

    // reserved offset, window edges
    do_store("rsvd9", 16'hFFF9, 16'h1111, 2'b11, 1'b1);
    chk("rsvd9 no change lo", count[31:0], 32'd0);
    chk("rsvd9 no change hi", 32'(count[95:32]), 32'd0);
    do_store("top", 16'hFFFF, 16'h2222, 2'b11, 1'b1);
    chk("top no change", 32'(count[95:0] != '0), 32'd0);
    do_store("below", 16'hFFEF, 16'h3333, 2'b11, 1'b0);
    chk("below no change", 32'(count[95:0] != '0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/counter_write_control.md
Name: counter_write_control

Overview:
- Write-side partner of the memory-mapped performance-counter read path.
- Owns the cache hit/miss counters (L2, I-cache, D-cache).
- Increments each counter on per-cycle event pulses.
- Services CPU stores to the counter window (clear/preset) with a mem_write/mem_resp handshake, so software can zero or preset counters before a measured region.
- Counter values feed the existing counter read mux unchanged.

Parameters:
- BASE_ADDR, 16'hFFF0: address of counter 0; counter k sits at BASE_ADDR+k.
- NUM_CNT, 6: number of counters, 1..16. Order: l2_miss, l2_hit, icache_miss, icache_hit, dcache_miss, dcache_hit.
- WINDOW, 16: size of the decoded window in addresses, starting at BASE_ADDR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_address  in  16  CPU data address.
- mem_write  in  1  store request; held high until mem_resp.
- mem_wdata  in  16  store data.
- mem_byte_enable  in  2  [1]=high byte, [0]=low byte.
- inc  in  NUM_CNT  per-cycle event pulse; bit k increments counter k.
- counter_write_sel  out  1  high when the current store address is inside the window; steers the store away from the cache.
- mem_resp  out  1  one-cycle store acknowledge.
- count  out  16*NUM_CNT  counter k on bits [16k+15:16k].

Behaviour:
- Reset (async): all counters 0, FSM to IDLE, mem_resp 0. counter_write_sel is combinational and depends only on address and mem_write.
- counter_write_sel = mem_write && BASE_ADDR <= mem_address < BASE_ADDR+WINDOW.
- FSM states: IDLE, COMMIT, DONE.
- IDLE:
  - On counter_write_sel=1, register the offset (mem_address-BASE_ADDR), mem_wdata and mem_byte_enable.
  - Go to COMMIT. No counter change from the store in this cycle.
- COMMIT:
  - mem_resp=1 for exactly this cycle.
  - If offset < NUM_CNT, counter[offset] is written at the end of the cycle with the registered data, per byte enable:
    - be=11: full word.
    - be=01: low byte only; high byte kept.
    - be=10: high byte only; low byte kept.
    - be=00: no change, still acknowledged.
  - Offsets >= NUM_CNT (reserved, read-only) are acknowledged and the data is discarded.
  - Next state: DONE.
- DONE:
  - mem_resp=0.
  - Return to IDLE in one cycle. This guarantees a held-over mem_write is not re-captured.
  - Latency: request seen in IDLE at cycle N, mem_resp at cycle N+1, next request accepted at N+3.
- Increment:
  - Every cycle, counter k <= counter k + 1 when inc[k]=1.
  - Wraps 16'hFFFF -> 16'h0000 by default.
  - Increments continue in all FSM states.
- Simultaneous write and increment on the same counter in COMMIT: the write wins; that cycle's increment is dropped. Other counters increment normally.
- mem_write deasserted while in COMMIT: the write still completes and mem_resp still pulses. No abort.
- Reset asserted mid-transaction: immediate return to IDLE, counters 0, mem_resp 0, no pending write survives.
- Address outside the window: FSM stays in IDLE, mem_resp stays 0 from this block.

Optional Feature:
- Macro PERF_COUNTER_SATURATE_EN.
- When defined: counters saturate at 16'hFFFF; further inc pulses leave them at 16'hFFFF until a store or reset.
- When undefined: modulo-2^16 wrap.
- Write/handshake behaviour is identical in both builds.

Test Plan:
- Reset, then inc[0] pulsed 5 cycles -> count[15:0]=5. All other counters stay 0.
- Store 16'h1234, be=11, to 16'hFFF3 -> counter_write_sel=1 in the request cycle, mem_resp high exactly one cycle later, counter 3 = 16'h1234. FSM back in IDLE 2 cycles after mem_resp.
- Preset counter 2 to 16'hABCD, then store 16'h0055 with be=01 to 16'hFFF2 -> counter 2 = 16'hAB55. Repeat with be=00 -> counter 2 unchanged, mem_resp still pulses.
- inc[4] held high continuously while storing 16'h0000 to 16'hFFF4 -> counter 4 reads 0 in the cycle after COMMIT, then 1, 2, ... Counter 5, with inc[5] held high, increments every cycle without interruption.
- Preset counter 1 to 16'hFFFE, pulse inc[1] 3 times:
  - Default build -> 16'h0001.
  - With PERF_COUNTER_SATURATE_EN -> 16'hFFFF.
- Reset edges and window edges:
  - Assert reset during COMMIT of a store to 16'hFFF0 -> counter 0 = 0, mem_resp drops immediately.
  - Store to 16'hFFF9 -> acknowledged, no counter changes.
  - Store to 16'hFFEF -> counter_write_sel=0, no mem_resp.
